// File: rtl/alu_req_arbiter_pkg.sv
// Shared opcode constants and FSM state encoding for the two-requester ALU arbiter.
package alu_req_arbiter_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_arbiter_alu4_core.sv
// Purely combinational 4-bit ALU: result, carry/borrow and even-parity of the result.
module alu4_core
    import alu_req_arbiter_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] result_o,
    output logic       carry_o,
    output logic       parity_o
);

    logic [4:0] sum5;
    logic [4:0] diff5;

    assign sum5  = {1'b0, a_i} + {1'b0, b_i};
    // Bit 4 of the 5-bit difference is the borrow: set exactly when a_i < b_i.
    assign diff5 = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = 4'd0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD:   begin result_o = sum5[3:0];  carry_o = sum5[4];  end
            OP_SUB:   begin result_o = diff5[3:0]; carry_o = diff5[4]; end
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_NOTA:  result_o = ~a_i;
            OP_PASSB: result_o = b_i;
            default:  result_o = 4'd0;
        endcase
    end

    assign parity_o = ^result_o;

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter feeding one shared 4-bit ALU; one operation in flight, IDLE -> EXEC -> RESP.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_chain,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_chain,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_parity,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic [3:0] last_q;
    logic       rsp_id_q;
    logic [3:0] rsp_result_q;
    logic       rsp_carry_q;
    logic       rsp_parity_q;

    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       chain_q;
    logic       id_q;

    logic       grant_any;
    logic       grant_id;
    logic [3:0] b_eff;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_parity;

    // The pointer only breaks ties; a lone request always wins.
    assign grant_any  = !rst && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign grant_id   = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    always_ff @(posedge clk) begin
        if (grant_any) begin
            op_q    <= grant_id ? req1_op    : req0_op;
            a_q     <= grant_id ? req1_a     : req0_a;
            b_q     <= grant_id ? req1_b     : req0_b;
            chain_q <= CHAIN_EN && (grant_id ? req1_chain : req0_chain);
            id_q    <= grant_id;
        end
    end

    assign b_eff = chain_q ? last_q : b_q;

    alu4_core u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_eff),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .parity_o (alu_parity)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rr_d    = ~rsp_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            last_q       <= 4'd0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_carry_q  <= 1'b0;
            rsp_parity_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (state_q == ST_EXEC) begin
                last_q       <= alu_result;
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result;
                rsp_carry_q  <= alu_carry;
                rsp_parity_q <= alu_parity;
            end
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_parity = rsp_parity_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed, table-driven bench for alu_req_arbiter plus hand-written multi-cycle sequences.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       req0_chain = 1'b0, req1_chain = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_parity, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.CHAIN_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_chain (req0_chain),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_chain (req1_chain),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_parity (rsp_parity),
        .busy       (busy)
    );

    typedef struct {
        logic       sel;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
        logic [3:0] r;
        logic       c;
        logic       p;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic chain);
        if (sel) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_chain = chain;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_chain = chain;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One complete transaction from a single requester with full latency checks.
    task automatic run_single(input string tag, input vec_t v);
        @(posedge clk); #1;
        drive(v.sel, v.op, v.a, v.b, v.chain);
        @(negedge clk);
        chk({tag, ".ready_sel"}, v.sel ? req1_ready : req0_ready, 1);
        chk({tag, ".ready_oth"}, v.sel ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, ".exec_rsp_valid"}, rsp_valid, 0);
        chk({tag, ".exec_busy"}, busy, 1);
        @(posedge clk); #1;
        chk({tag, ".rsp_valid"}, rsp_valid, 1);
        chk({tag, ".rsp_id"}, rsp_id, v.sel);
        chk({tag, ".result"}, rsp_result, v.r);
        chk({tag, ".carry"}, rsp_carry, v.c);
        chk({tag, ".parity"}, rsp_parity, v.p);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".after_hs_valid"}, rsp_valid, 0);
        chk({tag, ".after_hs_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        logic [3:0] held;
        vec_t v;

        //            sel   op      a      b      ch    r      c     p
        vecs[0] = '{1'b0, 3'd0, 4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b1}; // ADD 5+3
        vecs[1] = '{1'b1, 3'd4, 4'd12, 4'd7,  1'b1, 4'd4,  1'b0, 1'b1}; // XOR 1100 ^ last(1000)
        vecs[2] = '{1'b0, 3'd1, 4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b1}; // SUB 3-5 borrow
        vecs[3] = '{1'b0, 3'd0, 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0}; // ADD 15+1 carry
        vecs[4] = '{1'b1, 3'd3, 4'd3,  4'd4,  1'b0, 4'd7,  1'b0, 1'b1}; // OR
        vecs[5] = '{1'b0, 3'd5, 4'd5,  4'd2,  1'b0, 4'd8,  1'b0, 1'b1}; // NOR
        vecs[6] = '{1'b1, 3'd6, 4'd3,  4'd9,  1'b0, 4'd12, 1'b0, 1'b0}; // NOT A
        vecs[7] = '{1'b0, 3'd7, 4'd6,  4'd9,  1'b0, 4'd9,  1'b0, 1'b0}; // PASS B
        vecs[8] = '{1'b0, 3'd1, 4'd10, 4'd10, 1'b0, 4'd0,  1'b0, 1'b0}; // SUB equal, no borrow
        vecs[9] = '{1'b1, 3'd0, 4'd1,  4'd15, 1'b1, 4'd1,  1'b0, 1'b1}; // ADD 1 + last(0)

        // Reset values, with a request pending that must not see ready.
        @(posedge clk); #1;
        req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.req0_ready", req0_ready, 0);
        chk("rst.req1_ready", req1_ready, 0);
        chk("rst.rsp_id", rsp_id, 0);
        chk("rst.result", rsp_result, 0);
        chk("rst.carry", rsp_carry, 0);
        chk("rst.parity", rsp_parity, 0);
        @(posedge clk); @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b0;

        // Chain straight after reset reads the cleared last-result register.
        v = '{1'b0, 3'd7, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0};
        run_single("chain_after_rst", v);

        // Both requesters held valid: req0 first (pointer 0), then strict alternation.
        do_reset();
        drive(1'b0, 3'd1, 4'd10, 4'd4, 1'b0);
        drive(1'b1, 3'd2, 4'd12, 4'd10, 1'b0);
        rsp_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) chk("rr.both_ready", 1, 0);
            if (rsp_valid) begin
                chk("rr.id", rsp_id, n % 2);
                chk("rr.result", rsp_result, (n % 2) ? 4'd8 : 4'd6);
                chk("rr.parity", rsp_parity, (n % 2) ? 1 : 0);
                n++;
            end
        end
        chk("rr.responses_seen", n, 6);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

        // Vector table, single requester per row.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: response held five cycles while both requesters wait.
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 4'd9, 4'd9, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 3'd0, 4'd1, 4'd1, 1'b0);
        @(posedge clk); #1;
        held = rsp_result;
        chk("bp.result0", rsp_result, 2);
        chk("bp.carry0", rsp_carry, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.rsp_valid", rsp_valid, 1);
            chk("bp.busy", busy, 1);
            chk("bp.result_stable", rsp_result, held);
            chk("bp.no_ready", req0_ready | req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp.idle_busy", busy, 0);
        chk("bp.idle_valid", rsp_valid, 0);
        chk("bp.next_grant_req1", req1_ready, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset while holding a response: dropped at once, nothing after release.
        @(posedge clk); #1;
        drive(1'b0, 3'd0, 4'd1, 4'd1, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstresp.pre_valid", rsp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstresp.valid", rsp_valid, 0);
        chk("rstresp.busy", busy, 0);
        chk("rstresp.result", rsp_result, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstresp.no_rsp", rsp_valid, 0);
            chk("rstresp.no_busy", busy, 0);
        end
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
